dma_path_responder: RTL and testbench
=====================================

# dma_path_responder

Target-side end of the NPU load/store DMA path. Grants the initiator's `dma_req`, then accepts a 128-bit header beat on the write stream and decodes it. A write command (opcode 0x03) forwards the following payload beats to the host write port at consecutive 16-byte host addresses. A read command (opcode 0x01) issues credit-limited host reads and returns the data in order on the DMA read stream through an internal FIFO.

## Interface
Parameters:
- `RD_FIFO_DEPTH`, default 8: read-return FIFO entries and the maximum outstanding host reads; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dma_req`  in  1  initiator requests a transaction.
- `dma_resp`  out  1  one-cycle grant pulse.
- `dma_write_valid`  in  1  write-stream beat valid.
- `dma_write_data`  in  128  header or payload beat.
- `dma_write_ready`  out  1  write-stream ready.
- `dma_read_valid`  out  1  read-return beat valid.
- `dma_read_data`  out  128  read-return data.
- `dma_read_ready`  in  1  initiator accepts the return beat.
- `hst_wr_valid` / `hst_wr_ready`  out/in  1  host write handshake.
- `hst_wr_addr`  out  40  host byte address.
- `hst_wr_data`  out  128  host write data.
- `hst_rd_req_valid` / `hst_rd_req_ready`  out/in  1  host read-request handshake.
- `hst_rd_addr`  out  40  host read byte address.
- `hst_rd_valid`  in  1  host read data valid. Has no backpressure and arrives in request order.
- `hst_rd_data`  in  128  host read data.
- `cmd_local_addr`  out  14  localAddr field of the current command, held until the next header.
- `busy`  out  1  state ≠ IDLE.
- `err_opcode`  out  1  one-cycle pulse when an unknown opcode is received.

## Operation
- Header fields: [13:0] localAddr, [53:14] hostAddr, [69:54] length in beats, [77:70] opcode, [127:78] ignored.
- States and transitions:
  - IDLE: if `dma_req`, register `dma_resp`=1 for one cycle and go to HDR.
  - HDR: `dma_write_ready`=1. On a valid beat, latch addr/len/local, then branch:
    - opcode 0x03 and len>0: go to WR.
    - opcode 0x03 and len=0: go to IDLE.
    - opcode 0x01 and len>0: go to RD.
    - opcode 0x01 and len=0: go to IDLE.
    - any other opcode: pulse `err_opcode` and go to IDLE.
  - WR: `dma_write_ready`=`hst_wr_ready`; `hst_wr_valid`=`dma_write_valid`. Data passes combinationally and `hst_wr_addr`=base+(wcnt<<4). wcnt increments on each host handshake. When wcnt reaches len, go to IDLE.
  - RD: issue host read requests at base+(icnt<<4) while icnt<len and (outstanding+fifo_count)<RD_FIFO_DEPTH.
    - icnt and outstanding increment on a request handshake.
    - On each `hst_rd_valid`: push to the FIFO and decrement outstanding.
    - `dma_read_valid` = FIFO non-empty. Each pop (valid&&ready) increments rcnt.
    - When rcnt reaches len, go to IDLE.
- Address arithmetic is modulo 2^40; wrap is silent.
- Beat counters are 16-bit, so len=65535 is fully supported.
- `dma_req` seen outside IDLE is ignored. A grant is only issued from IDLE.
- FIFO overflow cannot occur by construction. A `hst_rd_valid` arriving with no outstanding request is a protocol violation; assert it in simulation.

## Timing
- Reset values:
  - 0: `dma_resp`, `dma_write_ready`, `dma_read_valid`, `hst_*_valid`, `busy`, `err_opcode`.
  - All address, data and `cmd_local_addr` outputs = 0.
  - FIFO empty, counters cleared, state IDLE.
- Grant: `dma_req` sampled high in cycle N → `dma_resp`=1 in N+1 only. HDR is entered at N+1, so `dma_write_ready`=1 from N+1.
- Write path: zero added latency (combinational pass-through). A sustained 1 beat/cycle requires `hst_wr_ready` held high.
- Read path:
  - First request is issued the cycle after the header is accepted.
  - Returned data is registered into the FIFO: `hst_rd_valid` at cycle M → `dma_read_valid` at M+1 at the earliest.
  - FIFO push and pop in the same cycle are both honoured, and the count is unchanged.
- `err_opcode` asserts the cycle after the bad header and lasts one cycle.
- `rst_n` deasserted mid-transaction: outputs go to their reset values immediately and in-flight data is discarded. Host returns arriving after reset release are undefined-input; this is a system requirement.

## Test plan
- `dma_req` pulse, then header {op 0x03, len 4, host 0x00_1000_0000, local 0x12} followed by 4 beats → 4 host writes at 0x1000_0000, +0x10, +0x20, +0x30; `cmd_local_addr`=0x12; returns to IDLE.
- Read header {op 0x01, len 20, host 0xFF_FFFF_FFF0}, host read latency 3, `dma_read_ready` toggling → addresses wrap to 0x00_0000_0000 on the second request; outstanding+count never exceeds 8; 20 beats returned in order.
- Header with opcode 0x07 → `err_opcode` pulses once; no host traffic; next `dma_req` is granted normally.
- Write with len=0, then read with len=0 → no host traffic; each returns to IDLE the cycle after the header.
- Write with `hst_wr_ready` held low for 5 cycles mid-burst → `dma_write_ready` is low for those same cycles; no beat lost or duplicated.
- `rst_n` asserted low during a read with 3 FIFO entries → `dma_read_valid`=0 and `busy`=0 immediately; after release, a new grant works.

Source files
------------

// File: rtl/dma_path_responder.sv
// Target-side DMA responder: grants a request, decodes one header beat, then either
// streams payload to the host write port or runs credit-limited host reads into a return FIFO.
module dma_path_responder #(
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dma_req,
    output logic         dma_resp,
    input  logic         dma_write_valid,
    input  logic [127:0] dma_write_data,
    output logic         dma_write_ready,
    output logic         dma_read_valid,
    output logic [127:0] dma_read_data,
    input  logic         dma_read_ready,
    output logic         hst_wr_valid,
    input  logic         hst_wr_ready,
    output logic [39:0]  hst_wr_addr,
    output logic [127:0] hst_wr_data,
    output logic         hst_rd_req_valid,
    input  logic         hst_rd_req_ready,
    output logic [39:0]  hst_rd_addr,
    input  logic         hst_rd_valid,
    input  logic [127:0] hst_rd_data,
    output logic [13:0]  cmd_local_addr,
    output logic         busy,
    output logic         err_opcode
);

    localparam int PW = $clog2(RD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(RD_FIFO_DEPTH);
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h03;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_WR, S_RD} state_t;

    state_t        state, state_nx;
    logic [39:0]   base_addr;
    logic [15:0]   len;
    logic [15:0]   wcnt, icnt, rcnt;
    logic [CW-1:0] outstanding, fifo_count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [127:0]  fifo_mem [RD_FIFO_DEPTH];

    logic [13:0]   hdr_local;
    logic [39:0]   hdr_host;
    logic [15:0]   hdr_len;
    logic [7:0]    hdr_op;
    logic          hdr_fire, hdr_known;
    logic          wr_fire, rd_req_fire, push, pop;
    logic [CW:0]   inflight;

    // Byte address of beat idx; 16-byte beats, silent wrap at 2^40.
    function automatic logic [39:0] beat_addr(input logic [39:0] base, input logic [15:0] idx);
        return base + {20'd0, idx, 4'd0};
    endfunction

    assign hdr_local   = dma_write_data[13:0];
    assign hdr_host    = dma_write_data[53:14];
    assign hdr_len     = dma_write_data[69:54];
    assign hdr_op      = dma_write_data[77:70];
    assign hdr_known   = (hdr_op == OP_READ) || (hdr_op == OP_WRITE);
    assign hdr_fire    = (state == S_HDR) && dma_write_valid;
    assign wr_fire     = (state == S_WR) && dma_write_valid && hst_wr_ready;
    assign rd_req_fire = hst_rd_req_valid && hst_rd_req_ready;
    assign push        = hst_rd_valid;
    assign pop         = dma_read_valid && dma_read_ready;
    assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};

    assign busy           = (state != S_IDLE);
    assign dma_read_valid = (fifo_count != '0);
    assign dma_read_data  = dma_read_valid ? fifo_mem[rd_ptr] : '0;

    always_comb begin
        state_nx         = state;
        dma_write_ready  = 1'b0;
        hst_wr_valid     = 1'b0;
        hst_wr_addr      = '0;
        hst_wr_data      = '0;
        hst_rd_req_valid = 1'b0;
        hst_rd_addr      = '0;
        case (state)
            S_IDLE: begin
                if (dma_req) state_nx = S_HDR;
            end
            S_HDR: begin
                dma_write_ready = 1'b1;
                if (dma_write_valid) begin
                    if (hdr_op == OP_WRITE && hdr_len != '0)     state_nx = S_WR;
                    else if (hdr_op == OP_READ && hdr_len != '0) state_nx = S_RD;
                    else                                         state_nx = S_IDLE;
                end
            end
            S_WR: begin
                dma_write_ready = hst_wr_ready;
                hst_wr_valid    = dma_write_valid;
                hst_wr_addr     = beat_addr(base_addr, wcnt);
                hst_wr_data     = dma_write_data;
                if (wr_fire && (wcnt + 16'd1 == len)) state_nx = S_IDLE;
            end
            S_RD: begin
                // Credit limit: every issued read must have a FIFO slot waiting for it.
                hst_rd_req_valid = (icnt < len) && (inflight < DEPTH_V);
                hst_rd_addr      = beat_addr(base_addr, icnt);
                if (pop && (rcnt + 16'd1 == len)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            dma_resp       <= 1'b0;
            err_opcode     <= 1'b0;
            cmd_local_addr <= '0;
            wcnt           <= '0;
            icnt           <= '0;
            rcnt           <= '0;
            outstanding    <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            state      <= state_nx;
            dma_resp   <= (state == S_IDLE) && dma_req;
            err_opcode <= hdr_fire && !hdr_known;
            if (hdr_fire) begin
                cmd_local_addr <= hdr_local;
                wcnt           <= '0;
                icnt           <= '0;
                rcnt           <= '0;
            end else begin
                if (wr_fire)     wcnt <= wcnt + 16'd1;
                if (rd_req_fire) icnt <= icnt + 16'd1;
                if (pop)         rcnt <= rcnt + 16'd1;
            end
            outstanding <= outstanding + CW'(rd_req_fire) - CW'(push);
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Header fields and FIFO storage carry data only; control decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (hdr_fire) begin
            base_addr <= hdr_host;
            len       <= hdr_len;
        end
        if (push) fifo_mem[wr_ptr] <= hst_rd_data;
    end

    a_rd_return_expected : assert property (@(posedge clk) disable iff (!rst_n)
        hst_rd_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_dma_path_responder.sv
// Bench for dma_path_responder: header decode table, write/read bursts with a
// latency-3 host model, and scoreboards for host writes, read addresses and return data.
module tb_dma_path_responder;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dma_req;
    logic         dma_resp;
    logic         dma_write_valid;
    logic [127:0] dma_write_data;
    logic         dma_write_ready;
    logic         dma_read_valid;
    logic [127:0] dma_read_data;
    logic         dma_read_ready;
    logic         hst_wr_valid;
    logic         hst_wr_ready;
    logic [39:0]  hst_wr_addr;
    logic [127:0] hst_wr_data;
    logic         hst_rd_req_valid;
    logic         hst_rd_req_ready;
    logic [39:0]  hst_rd_addr;
    logic         hst_rd_valid;
    logic [127:0] hst_rd_data;
    logic [13:0]  cmd_local_addr;
    logic         busy;
    logic         err_opcode;

    int checks = 0;
    int errors = 0;
    int n_req = 0;
    int n_ret = 0;
    int n_pop = 0;
    bit host_flush = 1'b0;

    logic [167:0] wr_exp[$];
    logic [39:0]  rda_exp[$];
    logic [127:0] rdd_exp[$];

    typedef struct {
        logic [7:0]  op;
        logic [15:0] len;
        logic [39:0] host;
        logic [13:0] loc;
        logic        exp_err;
    } hdr_vec_t;

    hdr_vec_t vecs[5];

    always #5 clk = ~clk;

    dma_path_responder #(.RD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_req(dma_req), .dma_resp(dma_resp),
        .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
        .dma_write_ready(dma_write_ready),
        .dma_read_valid(dma_read_valid), .dma_read_data(dma_read_data),
        .dma_read_ready(dma_read_ready),
        .hst_wr_valid(hst_wr_valid), .hst_wr_ready(hst_wr_ready),
        .hst_wr_addr(hst_wr_addr), .hst_wr_data(hst_wr_data),
        .hst_rd_req_valid(hst_rd_req_valid), .hst_rd_req_ready(hst_rd_req_ready),
        .hst_rd_addr(hst_rd_addr),
        .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data),
        .cmd_local_addr(cmd_local_addr), .busy(busy), .err_opcode(err_opcode)
    );

    function automatic logic [127:0] mk_hdr(input logic [7:0] op, input logic [15:0] len,
                                            input logic [39:0] host, input logic [13:0] loc);
        return {50'd0, op, len, host, loc};
    endfunction

    function automatic logic [127:0] rd_pat(input logic [39:0] a);
        return {24'hC0FFEE, a, 24'h5A5A5A, ~a};
    endfunction

    function automatic logic [127:0] wr_pat(input int i, input int seed);
        return {32'hBEEF_0000 + 32'(i), 32'(seed), ~32'(i), 32'hCAFE_0000 ^ 32'(i * 7 + seed)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_grant();
        dma_req = 1'b1;
        step();
        check1("grant_resp", dma_resp, 1'b1);
        check1("grant_wready", dma_write_ready, 1'b1);
        check1("grant_busy", busy, 1'b1);
        dma_req = 1'b0;
        step();
        check1("grant_pulse_end", dma_resp, 1'b0);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len,
                            input logic [39:0] host, input logic [13:0] loc);
        dma_write_valid = 1'b1;
        dma_write_data  = mk_hdr(op, len, host, loc);
        step();
        dma_write_valid = 1'b0;
        dma_write_data  = '0;
    endtask

    task automatic send_payload(input int n, input logic [39:0] base, input int stall_at,
                                input int stall_len, input bit hold_req, input int seed);
        int i = 0;
        int pushed = 0;
        int cyc = 0;
        while (i < n && cyc < n + stall_len + 20) begin
            dma_write_valid = 1'b1;
            dma_write_data  = wr_pat(i, seed);
            hst_wr_ready    = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            dma_req         = hold_req;
            if (pushed == i) begin
                wr_exp.push_back({base + 40'(i * 16), wr_pat(i, seed)});
                pushed++;
            end
            #1;
            check1("wr_ready_follows_host", dma_write_ready, hst_wr_ready);
            if (hold_req) check1("no_grant_outside_idle", dma_resp, 1'b0);
            @(posedge clk);
            #1;
            if (hst_wr_ready) i++;
            cyc++;
        end
        if (i < n) begin
            errors++;
            $display("FAIL payload_timeout: sent %0d beats, required %0d", i, n);
        end
        dma_write_valid = 1'b0;
        dma_write_data  = '0;
        hst_wr_ready    = 1'b1;
        dma_req         = 1'b0;
    endtask

    // Host read model: fixed latency of 3 cycles, returns in request order.
    initial begin
        logic        pv[3];
        logic [39:0] pa[3];
        logic        hs;
        logic [39:0] hsa;
        for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pa[k] = '0; end
        hst_rd_valid = 1'b0;
        hst_rd_data  = '0;
        forever begin
            @(negedge clk);
            hs  = hst_rd_req_valid && hst_rd_req_ready && rst_n;
            hsa = hst_rd_addr;
            @(posedge clk);
            #1;
            if (host_flush) begin
                for (int k = 0; k < 3; k++) pv[k] = 1'b0;
            end else begin
                pv[2] = pv[1]; pa[2] = pa[1];
                pv[1] = pv[0]; pa[1] = pa[0];
                pv[0] = hs;    pa[0] = hsa;
            end
            hst_rd_valid = pv[2];
            hst_rd_data  = pv[2] ? rd_pat(pa[2]) : '0;
        end
    end

    // Scoreboard monitor: evaluates handshakes half a cycle before the edge that takes them.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hst_wr_valid && hst_wr_ready) begin
                    if (wr_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_host_write: addr %0h", hst_wr_addr);
                    end else checkw("host_write", {hst_wr_addr, hst_wr_data}, wr_exp.pop_front());
                end
                if (hst_rd_req_valid && hst_rd_req_ready) begin
                    n_req++;
                    if (rda_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_host_read: addr %0h", hst_rd_addr);
                    end else checkw("host_read_addr", 168'(hst_rd_addr), 168'(rda_exp.pop_front()));
                end
                if (hst_rd_valid) n_ret++;
                if (dma_read_valid && dma_read_ready) begin
                    n_pop++;
                    if (rdd_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read_return: data %0h", dma_read_data);
                    end else checkw("read_return", 168'(dma_read_data), 168'(rdd_exp.pop_front()));
                end
                if (n_req - n_pop > DEPTH) begin
                    errors++;
                    $display("FAIL read_credit: in flight %0d, limit %0d", n_req - n_pop, DEPTH);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] base;

        vecs[0] = '{8'h07, 16'd3, 40'h12_3456_7890, 14'h3FFF, 1'b1};
        vecs[1] = '{8'h03, 16'd0, 40'h00_0000_1000, 14'h0001, 1'b0};
        vecs[2] = '{8'h01, 16'd0, 40'h00_0000_2000, 14'h0002, 1'b0};
        vecs[3] = '{8'h00, 16'd5, 40'hAA_0000_0000, 14'h1555, 1'b1};
        vecs[4] = '{8'hFF, 16'd1, 40'h00_FFFF_0000, 14'h2AAA, 1'b1};

        rst_n            = 1'b0;
        dma_req          = 1'b0;
        dma_write_valid  = 1'b0;
        dma_write_data   = '0;
        dma_read_ready   = 1'b0;
        hst_wr_ready     = 1'b1;
        hst_rd_req_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check1("rst_resp", dma_resp, 1'b0);
        check1("rst_wready", dma_write_ready, 1'b0);
        check1("rst_rvalid", dma_read_valid, 1'b0);
        check1("rst_hwvalid", hst_wr_valid, 1'b0);
        check1("rst_hrvalid", hst_rd_req_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err_opcode, 1'b0);
        checkw("rst_addrs_local", {hst_wr_addr, hst_rd_addr, 74'd0, cmd_local_addr}, '0);
        checkw("rst_rdata", 168'(dma_read_data), '0);
        rst_n = 1'b1;
        step();

        // Header decode table: unknown opcodes and zero-length commands
        for (int k = 0; k < 5; k++) begin
            do_grant();
            send_hdr(vecs[k].op, vecs[k].len, vecs[k].host, vecs[k].loc);
            check1($sformatf("tbl%0d_err", k), err_opcode, vecs[k].exp_err);
            check1($sformatf("tbl%0d_idle", k), busy, 1'b0);
            checkw($sformatf("tbl%0d_local", k), 168'(cmd_local_addr), 168'(vecs[k].loc));
            check1($sformatf("tbl%0d_no_hwr", k), hst_wr_valid, 1'b0);
            check1($sformatf("tbl%0d_no_hrd", k), hst_rd_req_valid, 1'b0);
            step();
            check1($sformatf("tbl%0d_err_once", k), err_opcode, 1'b0);
        end

        // Write burst of 4 beats
        do_grant();
        send_hdr(8'h03, 16'd4, 40'h00_1000_0000, 14'h0012);
        check1("wr4_busy", busy, 1'b1);
        checkw("wr4_local", 168'(cmd_local_addr), 168'(14'h0012));
        checkw("wr4_first_addr", 168'(hst_wr_addr), 168'(40'h00_1000_0000));
        send_payload(4, 40'h00_1000_0000, 0, 0, 1'b0, 11);
        check1("wr4_idle", busy, 1'b0);
        checkw("wr4_drained", 168'(wr_exp.size()), '0);

        // Write burst with host stall mid-burst and dma_req held during the burst
        do_grant();
        send_hdr(8'h03, 16'd8, 40'hAB_CDEF_0000, 14'h002A);
        send_payload(8, 40'hAB_CDEF_0000, 3, 5, 1'b1, 22);
        check1("wrstall_idle", busy, 1'b0);
        checkw("wrstall_drained", 168'(wr_exp.size()), '0);
        step();
        check1("wrstall_no_late_grant", dma_resp, 1'b0);

        // Read burst of 20 with address wrap and toggling dma_read_ready
        base = 40'hFF_FFFF_FFF0;
        n_req = 0; n_ret = 0; n_pop = 0;
        do_grant();
        for (int i = 0; i < 20; i++) begin
            rda_exp.push_back(base + 40'(i * 16));
            rdd_exp.push_back(rd_pat(base + 40'(i * 16)));
        end
        send_hdr(8'h01, 16'd20, base, 14'h00AB);
        check1("rd_busy", busy, 1'b1);
        check1("rd_first_req", hst_rd_req_valid, 1'b1);
        checkw("rd_first_addr", 168'(hst_rd_addr), 168'(40'hFF_FFFF_FFF0));
        step();
        check1("rd_second_req", hst_rd_req_valid, 1'b1);
        checkw("rd_wrap_addr", 168'(hst_rd_addr), '0);
        for (int c = 0; c < 600 && busy; c++) begin
            dma_read_ready = c[0];
            step();
        end
        dma_read_ready = 1'b0;
        check1("rd_done_idle", busy, 1'b0);
        checkw("rd_pops", 168'(n_pop), 168'(20));
        checkw("rd_drained", 168'(rdd_exp.size() + rda_exp.size()), '0);
        check1("rd_fifo_empty", dma_read_valid, 1'b0);

        // Reset during a read with 3 FIFO entries
        base = 40'h00_0200_0000;
        n_req = 0; n_ret = 0; n_pop = 0;
        do_grant();
        for (int i = 0; i < 10; i++) begin
            rda_exp.push_back(base + 40'(i * 16));
            rdd_exp.push_back(rd_pat(base + 40'(i * 16)));
        end
        send_hdr(8'h01, 16'd10, base, 14'h0155);
        for (int c = 0; c < 50 && n_ret < 3; c++) step();
        if (n_ret < 3) begin
            errors++;
            $display("FAIL rst_wait_returns: got %0d returns, required 3", n_ret);
        end
        check1("rstmid_pre_rvalid", dma_read_valid, 1'b1);
        rst_n      = 1'b0;
        host_flush = 1'b1;
        #1;
        check1("rstmid_rvalid", dma_read_valid, 1'b0);
        check1("rstmid_busy", busy, 1'b0);
        check1("rstmid_hrvalid", hst_rd_req_valid, 1'b0);
        checkw("rstmid_local", 168'(cmd_local_addr), '0);
        rda_exp.delete();
        rdd_exp.delete();
        step();
        step();
        rst_n = 1'b1;
        n_req = 0; n_ret = 0; n_pop = 0;
        step();
        host_flush = 1'b0;
        step();
        check1("rstmid_after_rvalid", dma_read_valid, 1'b0);
        check1("rstmid_after_idle", busy, 1'b0);

        do_grant();
        send_hdr(8'h03, 16'd2, 40'h00_0000_0F00, 14'h0003);
        checkw("post_rst_local", 168'(cmd_local_addr), 168'(14'h0003));
        send_payload(2, 40'h00_0000_0F00, 0, 0, 1'b0, 33);
        check1("post_rst_idle", busy, 1'b0);
        checkw("post_rst_drained", 168'(wr_exp.size()), '0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
